// File: rtl/serial_alu_exec_if.sv
// serial_alu_exec_if
//   Operand/result bundle between an operation source and serial_alu_exec.
//
//   Ports:
//     in_valid, A, B, OP : operation offered by the source
//     in_ready           : serial_alu_exec can take an operation
//     out_valid, Y       : result offered by serial_alu_exec
//     out_ready          : sink takes Y
//
//   Modports: master = operation source / result sink, slave = the execution unit.
interface serial_alu_exec_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OP;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   Y;

  modport master (
    output in_valid, A, B, OP, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, A, B, OP, out_ready,
    output in_ready, out_valid, Y
  );
endinterface

// File: rtl/serial_alu_exec.sv
// serial_alu_exec
//   Bit-serial add/subtract unit. An operation (A, B, OP) is taken in IDLE,
//   computed LSB-first one bit per clock over WIDTH cycles in CALC, and the
//   {carry, sum} result is held in DONE until the sink takes it. op_count
//   counts consumed results and wraps.
//
//   Ports:
//     clk       : clock, rising edge
//     reset     : asynchronous active-low reset
//     bus       : serial_alu_exec_if.slave (in_valid/in_ready/A/B/OP,
//                 out_valid/out_ready/Y)
//     op_count  : consumed-result counter, wraps modulo 2^CNT_W
//     dbg_state : current FSM state (0 = IDLE, 1 = CALC, 2 = DONE)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready depends only on state (never on in_valid); out_valid
//   and Y stay constant from the rise of out_valid until the transfer edge.
//   The unit never accepts and delivers on the same edge.
//
//   WIDTH must be at least 2.
module serial_alu_exec #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  serial_alu_exec_if.slave bus,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             op_r;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             out_valid_r;
  logic [WIDTH:0]   y_r;

  // One full-adder slice; subtract inverts B and starts with carry = 1.
  logic b_bit;
  logic sum_bit;
  logic carry_nxt;

  always_comb begin
    b_bit     = b_sh[0] ^ op_r;
    sum_bit   = a_sh[0] ^ b_bit ^ carry;
    carry_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      op_r        <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            op_r  <= bus.OP;
            carry <= bus.OP;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
          carry  <= carry_nxt;
          idx    <= idx + IDX_W'(1);
          if (idx == IDX_W'(WIDTH - 1)) begin
            // Last bit: assemble Y directly from the current slice so it is
            // ready on the same edge that enters DONE.
            y_r         <= {carry_nxt, sum_bit, res_sh[WIDTH-1:1]};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            op_count    <= op_count + CNT_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.Y         = y_r;
  assign dbg_state     = state;

endmodule

// File: doc/serial_alu_exec.md
# serial_alu_exec

Bit-serial execution unit that receives the operand/opcode stream produced by the team's `controller` block (5-bit A, 5-bit B, 1-bit OP) and returns the result. Each operation is accepted through a valid/ready handshake and computed LSB-first, one bit per clock over 5 cycles. The result is held on a valid/ready output port until the downstream side takes it. A wrapping counter records completed operations for debug and coverage.

## Interface
- `WIDTH`, 5: operand width; result width is WIDTH+1.
- `CNT_W`, 8: width of the completed-operation counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `in_valid`  in  1  A/B/OP are valid this cycle.
- `in_ready`  out  1  block can accept an operation; high only in IDLE.
- `A`  in  WIDTH  operand A, unsigned.
- `B`  in  WIDTH  operand B, unsigned.
- `OP`  in  1  0 = add, 1 = subtract.
- `out_valid`  out  1  `Y` holds a new result.
- `out_ready`  in  1  downstream accepts `Y`.
- `Y`  out  WIDTH+1  result: {carry, sum[WIDTH-1:0]}.
- `op_count`  out  CNT_W  number of results consumed; wraps modulo 2^CNT_W.

## Operation
- **States.** IDLE, CALC, DONE. After reset the state is IDLE.
- **IDLE.**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture A and B into shift registers and capture OP.
  - Set the carry register to OP (carry-in 1 for subtract).
  - Clear the bit index. Go to CALC.
- **CALC.** Each cycle:
  - `s = a0 ^ b0' ^ c` and `c' = maj(a0, b0', c)`, where `b0' = b0 ^ OP_reg`.
  - Shift `s` into the result register from the MSB side; shift A and B right; increment the index.
  - When the index reaches WIDTH-1, that is the last bit. Load `Y = {c', sum}`, set `out_valid`, go to DONE.
  - `in_valid` is ignored throughout CALC.
- **DONE.**
  - `out_valid` = 1 and `Y` is stable.
  - On `out_ready`: clear `out_valid`, increment `op_count`, go to IDLE.
  - `in_valid` is ignored throughout DONE.
- **Arithmetic.**
  - Add: `Y = A + B`, 6-bit, no loss.
  - Subtract: `Y = A + ~B + 1`.
    - `Y[5]` = 1 means A >= B (no borrow); `Y[4:0]` = (A - B) mod 32.
- **`Y` update rule.** `Y` changes only on entry to DONE. It keeps the previous result through IDLE and CALC.
- **Counter.** `op_count` increments only on the output handshake and wraps from 2^CNT_W-1 to 0.

## Timing
- **Reset values (while `reset` is 0, asynchronously):**
  - state = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `Y` = 0, `op_count` = 0, all internal shift/carry/index registers = 0.
- **Reset mid-operation.** Reset during CALC or DONE aborts the operation. The result is discarded and `op_count` is unchanged from its reset value of 0.
- **Latency.** Accept edge k; `out_valid` rises after edge k+WIDTH (5 cycles).
- **Throughput.** With `out_ready` tied high: accept at k, result consumed at edge k+6, `in_ready` high again at edge k+6, next accept at k+7.
- **`in_ready`.** Decoded from state (combinational). It is low from the accept edge until the output handshake edge.
- **Backpressure.** `out_valid` and `Y` are held unchanged for any number of cycles while `out_ready` = 0.
- **`out_ready` outside DONE.** If `out_ready` is high while not in DONE, nothing happens.
- **Simultaneous events.** There is no overlap: a new operation is never accepted in the same cycle a result is consumed. The DONE→IDLE edge and the next accept edge are distinct.

## Test plan
- **Reset.** Hold `reset` = 0 for 2 cycles → `in_ready` = 1, `out_valid` = 0, `Y` = 6'b000000, `op_count` = 0.
- **Add, with and without overflow** (`out_ready` = 1).
  - A = 00011, B = 00101, OP = 0 → `out_valid` 5 cycles after accept, `Y` = 6'b001000, `op_count` = 1.
  - A = 11111, B = 11111 → `Y` = 6'b111110.
- **Subtract.**
  - A = 00101, B = 00011, OP = 1 → `Y` = 6'b100010.
  - A = 00011, B = 00101, OP = 1 → `Y` = 6'b011110.
- **Backpressure and ignored inputs.**
  - Hold `out_ready` = 0 for 3 cycles in DONE → `Y` and `out_valid` stable, `in_ready` = 0.
  - Toggle `in_valid` with new operands during CALC and DONE → ignored; result unchanged.
- **Reset mid-CALC.**
  - Assert `reset` = 0 two cycles after accept → `out_valid` stays 0 and `Y` = 0.
  - After release, A = 00001, B = 00001, OP = 0 → `Y` = 6'b000010.
- **Counter wrap.** Complete 256 back-to-back operations → `op_count` reads 0 after the 256th handshake; measured spacing between accepts is 7 cycles.
